// File: rtl/div_ctrl_pkg.sv
// Shared encodings and helpers for the radix-2 divider control block.
// State names and handshake levels used by div_ctrl live here.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int unsigned DIV_W = 32;

  // counter value on the edge that completes the 32nd iteration
  localparam logic [5:0] DIV_LAST_ITER = 6'd31;

  // two's complement when neg is set, pass-through otherwise
  function automatic logic [DIV_W-1:0] neg_if(
    input logic             neg,
    input logic [DIV_W-1:0] v
  );
    return neg ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned 32-bit divider with start/annul handshake.
// Restoring radix-2: one quotient bit per cycle, result {rem, quot}.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  div_state_e  r_state;
  div_state_e  w_state_nxt;

  logic [64:0] r_shift;
  logic [31:0] r_divisor;
  logic [5:0]  r_cnt;
  logic        r_sign1;
  logic        r_sign2;
  logic        r_ready;
  logic [63:0] r_result;

  logic        w_load;
  logic        w_ready_nxt;
  logic [63:0] w_result_nxt;

  logic        w_neg1;
  logic        w_neg2;
  logic [33:0] w_shifted;
  logic [33:0] w_trial;
  logic        w_qbit;
  logic [32:0] w_rem_nxt;
  logic [64:0] w_shift_nxt;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_neg1 = signed_div_i & opdata1_i[31];
  assign w_neg2 = signed_div_i & opdata2_i[31];

  // one restoring step: shift left, trial-subtract, keep or restore
  always_comb begin
    w_shifted   = r_shift[64:31];
    w_trial     = w_shifted - {2'b00, r_divisor};
    w_qbit      = ~w_trial[33];
    w_rem_nxt   = w_qbit ? w_trial[32:0] : w_shifted[32:0];
    w_shift_nxt = {w_rem_nxt, r_shift[30:0], w_qbit};
    w_quot_fix  = neg_if(r_sign1 ^ r_sign2, w_shift_nxt[31:0]);
    w_rem_fix   = neg_if(r_sign1, w_shift_nxt[63:32]);
  end

  // next state and registered outputs, annul wins over progress
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_ready_nxt  = r_ready;
    w_result_nxt = r_result;
    unique case (r_state)
      DivFree: begin
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = 64'h0;
        if (start_i == DivStart && !annul_i) begin
          w_load      = 1'b1;
          w_state_nxt = (opdata2_i == 32'h0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = 64'h0;
        end else begin
          w_state_nxt  = DivEnd;
          w_ready_nxt  = DivResultReady;
          w_result_nxt = 64'h0;
        end
      end
      DivOn: begin
        if (annul_i) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = 64'h0;
        end else if (r_cnt == DIV_LAST_ITER) begin
          w_state_nxt  = DivEnd;
          w_ready_nxt  = DivResultReady;
          w_result_nxt = {w_rem_fix, w_quot_fix};
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = 64'h0;
        end
      end
      default: begin
        w_state_nxt  = DivFree;
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = 64'h0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DivFree;
      r_ready  <= DivResultNotReady;
      r_result <= 64'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= w_ready_nxt;
      r_result <= w_result_nxt;
    end
  end

  // operand latch on acceptance, then one iteration per ON cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= 65'h0;
      r_divisor <= 32'h0;
      r_cnt     <= 6'd0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
    end else if (w_load) begin
      r_shift   <= {33'h0, neg_if(w_neg1, opdata1_i)};
      r_divisor <= neg_if(w_neg2, opdata2_i);
      r_cnt     <= 6'd0;
      r_sign1   <= w_neg1;
      r_sign2   <= w_neg2;
    end else if (r_state == DivOn) begin
      r_shift   <= w_shift_nxt;
      r_cnt     <= r_cnt + 6'd1;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state == DivOn);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: transaction-level model
// compared every cycle, plus directed literal cases.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // plain-arithmetic reference: {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint q;
    longint r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'h0, a}) / longint'({32'h0, b});
      r = longint'({32'h0, a}) % longint'({32'h0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // transaction-level expectation: accept, fixed latency, hold, release
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t        m_ph   = M_IDLE;
  int          m_n    = 0;
  int          m_lat  = 0;
  logic [63:0] m_res  = '0;
  logic        e_rdy  = 1'b0;
  logic        e_busy = 1'b0;
  logic [63:0] e_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph   <= M_IDLE;
      e_rdy  <= 1'b0;
      e_busy <= 1'b0;
      e_res  <= '0;
    end else begin
      case (m_ph)
        M_IDLE: begin
          if (start_i && !annul_i) begin
            m_lat  <= (opdata2_i == 0) ? 1 : 32;
            m_n    <= 0;
            m_res  <= ref_div(signed_div_i, opdata1_i, opdata2_i);
            m_ph   <= M_RUN;
            e_busy <= (opdata2_i != 0);
          end
        end
        M_RUN: begin
          if (annul_i) begin
            m_ph   <= M_IDLE;
            e_busy <= 1'b0;
            e_rdy  <= 1'b0;
            e_res  <= '0;
          end else begin
            m_n <= m_n + 1;
            if (m_n + 1 == m_lat) begin
              m_ph   <= M_DONE;
              e_rdy  <= 1'b1;
              e_res  <= m_res;
              e_busy <= 1'b0;
            end
          end
        end
        M_DONE: begin
          if (annul_i || !start_i) begin
            m_ph  <= M_IDLE;
            e_rdy <= 1'b0;
            e_res <= '0;
          end
        end
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", {63'h0, ready_o}, {63'h0, e_rdy});
      chk("cyc_busy", {63'h0, busy_o}, {63'h0, e_busy});
      chk("cyc_result", result_o, e_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full operation; measures edges from accept to ready
  task automatic run_op(input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        input logic use_lit, input logic [63:0] lit,
                        input string name);
    int n;
    logic [63:0] got;
    tick();
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    n = 0;
    while (!ready_o && n < 40) begin
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
      tick();
      n++;
    end
    chk({name, "_lat"}, 64'(n), (b == 0) ? 64'd1 : 64'd32);
    got = result_o;
    if (use_lit) chk({name, "_res"}, got, lit);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, "_hold_rdy"}, {63'h0, ready_o}, 64'h1);
      chk({name, "_hold_res"}, result_o, got);
    end
    start_i = 1'b0;
    tick();
    chk({name, "_rel_rdy"}, {63'h0, ready_o}, 64'h0);
    chk({name, "_rel_res"}, result_o, 64'h0);
  endtask

  // accept an op, then annul k edges after acceptance
  task automatic annul_op(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int k,
                          input logic keep_start);
    tick();
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    repeat (k) tick();
    annul_i = 1'b1;
    start_i = keep_start;
    tick();
    annul_i = 1'b0;
    start_i = 1'b0;
    chk("annul_rdy", {63'h0, ready_o}, 64'h0);
    chk("annul_busy", {63'h0, busy_o}, 64'h0);
    chk("annul_res", result_o, 64'h0);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_ready", {63'h0, ready_o}, 64'h0);
    chk("rst_busy", {63'h0, busy_o}, 64'h0);
    chk("rst_result", result_o, 64'h0);
    rst = 1'b0;

    chk("pin_100_7", ref_div(1'b0, 32'd100, 32'd7),
        64'h00000002_0000000E);
    chk("pin_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2),
        64'hFFFFFFFF_FFFFFFFD);
    chk("pin_ovf_s", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF),
        64'h00000000_80000000);
    chk("pin_ovf_u", ref_div(1'b0, 32'h80000000, 32'hFFFFFFFF),
        64'h80000000_00000000);

    run_op(1'b0, 32'd100, 32'd7, 2, 1'b1, 64'h00000002_0000000E, "u100_7");
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "sm7_2");
    run_op(1'b1, 32'd5, 32'd0, 2, 1'b1, 64'h0, "div0");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1,
           64'h00000000_80000000, "ovf_s");
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 1'b1,
           64'h80000000_00000000, "ovf_u");
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0, 1'b1, 64'h00000001_FFFFFFFD, "s7_m2");

    annul_op(1'b0, 32'd1000, 32'd3, 9, 1'b0);
    repeat (40) begin
      chk("annul_no_rdy", {63'h0, ready_o}, 64'h0);
      tick();
    end
    run_op(1'b0, 32'd1000, 32'd10, 1, 1'b1, 64'h00000000_00000064, "after_annul");

    tick();
    signed_div_i = 1'b0;
    opdata1_i    = 32'hDEADBEEF;
    opdata2_i    = 32'd17;
    start_i      = 1'b1;
    tick();
    repeat (19) tick();
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_rdy", {63'h0, ready_o}, 64'h0);
    chk("midrst_busy", {63'h0, busy_o}, 64'h0);
    chk("midrst_res", result_o, 64'h0);
    run_op(1'b0, 32'hDEADBEEF, 32'd17, 5, 1'b1,
           ref_div(1'b0, 32'hDEADBEEF, 32'd17), "hold5");

    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'd1;
        3: b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0)
        annul_op(s, a, b, $urandom_range(0, 34), 1'($urandom));
      else
        run_op(s, a, b, $urandom_range(0, 3), 1'b0, 64'h0, "rnd");
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
